// File: rtl/core_exu_ctrl.sv
// Issue/sequencing controller for core_exu: register scoreboard, RAW/WAW stall,
// and start/writeback sequencing of the shared multi-cycle (mul/div) unit.
module core_exu_ctrl #(
    parameter int RFIDX_W = 5,
    parameter int NREG    = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid_i,
    output logic               id_ready_o,
    input  logic [RFIDX_W-1:0] rs1_idx_i,
    input  logic               rs1_ren_i,
    input  logic [RFIDX_W-1:0] rs2_idx_i,
    input  logic               rs2_ren_i,
    input  logic [RFIDX_W-1:0] rsd_idx_i,
    input  logic               rsd_wen_i,
    input  logic               id_mc_i,
    input  logic               id_ld_i,
    input  logic               flush_i,
    output logic               ex_valid_o,
    output logic [RFIDX_W-1:0] ex_rsd_idx_o,
    output logic               mc_start_o,
    input  logic               mc_done_i,
    output logic               mc_busy_o,
    output logic               mc_wb_o,
    output logic [RFIDX_W-1:0] mc_rsd_idx_o,
    input  logic               wb_valid_i,
    input  logic [RFIDX_W-1:0] wb_idx_i,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_WB
    } state_e;

    state_e             state_q, state_d;
    logic [NREG-1:0]    sb_q, sb_d;
    logic               ex_valid_q, ex_valid_d;
    logic [RFIDX_W-1:0] ex_rsd_idx_q, ex_rsd_idx_d;
    logic               mc_start_q, mc_start_d;
    logic [RFIDX_W-1:0] mc_idx_q, mc_idx_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic haz_rs1, haz_rs2, haz_rsd, haz, fire, stall;

    // Hazards look only at the registered scoreboard, so a clear never bypasses.
    assign haz_rs1 = rs1_ren_i && (rs1_idx_i != '0) && sb_q[rs1_idx_i];
    assign haz_rs2 = rs2_ren_i && (rs2_idx_i != '0) && sb_q[rs2_idx_i];
    assign haz_rsd = rsd_wen_i && (rsd_idx_i != '0) && sb_q[rsd_idx_i];
    assign haz     = haz_rs1 || haz_rs2 || haz_rsd;

    assign id_ready_o = !haz && (state_q == S_IDLE);
    assign fire       = id_valid_i && id_ready_o && !flush_i;
    assign stall      = id_valid_i && !id_ready_o && !flush_i;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves a latch behind.
        state_d      = state_q;
        sb_d         = sb_q;
        ex_valid_d   = 1'b0;
        ex_rsd_idx_d = ex_rsd_idx_q;
        mc_start_d   = 1'b0;
        mc_idx_d     = mc_idx_q;
        stall_cnt_d  = stall_cnt_q;

        if (fire) begin
            ex_valid_d   = 1'b1;
            ex_rsd_idx_d = rsd_idx_i;
        end

        // Clears first, then sets, so a same-bit collision resolves to set.
        if (wb_valid_i && (wb_idx_i != '0)) begin
            sb_d[wb_idx_i] = 1'b0;
        end
        if (state_q == S_WB) begin
            sb_d[mc_idx_q] = 1'b0;
        end
        if (fire && (id_mc_i || id_ld_i) && rsd_wen_i && (rsd_idx_i != '0)) begin
            sb_d[rsd_idx_i] = 1'b1;
        end
        sb_d[0] = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (fire && id_mc_i) begin
                    state_d    = S_BUSY;
                    mc_idx_d   = rsd_idx_i;
                    mc_start_d = 1'b1;
                end
            end
            S_BUSY: begin
                if (mc_done_i) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all update together at the edge.
        if (rst) begin
            state_q      <= S_IDLE;
            sb_q         <= '0;
            ex_valid_q   <= 1'b0;
            ex_rsd_idx_q <= '0;
            mc_start_q   <= 1'b0;
            mc_idx_q     <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sb_q         <= sb_d;
            ex_valid_q   <= ex_valid_d;
            ex_rsd_idx_q <= ex_rsd_idx_d;
            mc_start_q   <= mc_start_d;
            mc_idx_q     <= mc_idx_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_rsd_idx_o = ex_rsd_idx_q;
    assign mc_start_o   = mc_start_q;
    assign mc_busy_o    = (state_q != S_IDLE);
    assign mc_wb_o      = (state_q == S_WB);
    assign mc_rsd_idx_o = mc_idx_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_core_exu_ctrl.sv
// Self-checking bench for core_exu_ctrl: directed scenarios plus randomized
// traffic, all compared against a per-register pending-write reference model.
module tb_core_exu_ctrl;

    localparam int RFIDX_W = 5;
    localparam int NREG    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst;
    logic               id_valid_i;
    logic               id_ready_o;
    logic [RFIDX_W-1:0] rs1_idx_i;
    logic               rs1_ren_i;
    logic [RFIDX_W-1:0] rs2_idx_i;
    logic               rs2_ren_i;
    logic [RFIDX_W-1:0] rsd_idx_i;
    logic               rsd_wen_i;
    logic               id_mc_i;
    logic               id_ld_i;
    logic               flush_i;
    logic               ex_valid_o;
    logic [RFIDX_W-1:0] ex_rsd_idx_o;
    logic               mc_start_o;
    logic               mc_done_i;
    logic               mc_busy_o;
    logic               mc_wb_o;
    logic [RFIDX_W-1:0] mc_rsd_idx_o;
    logic               wb_valid_i;
    logic [RFIDX_W-1:0] wb_idx_i;
    logic [CNT_W-1:0]   stall_cnt_o;

    core_exu_ctrl #(
        .RFIDX_W (RFIDX_W),
        .NREG    (NREG),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid_i   (id_valid_i),
        .id_ready_o   (id_ready_o),
        .rs1_idx_i    (rs1_idx_i),
        .rs1_ren_i    (rs1_ren_i),
        .rs2_idx_i    (rs2_idx_i),
        .rs2_ren_i    (rs2_ren_i),
        .rsd_idx_i    (rsd_idx_i),
        .rsd_wen_i    (rsd_wen_i),
        .id_mc_i      (id_mc_i),
        .id_ld_i      (id_ld_i),
        .flush_i      (flush_i),
        .ex_valid_o   (ex_valid_o),
        .ex_rsd_idx_o (ex_rsd_idx_o),
        .mc_start_o   (mc_start_o),
        .mc_done_i    (mc_done_i),
        .mc_busy_o    (mc_busy_o),
        .mc_wb_o      (mc_wb_o),
        .mc_rsd_idx_o (mc_rsd_idx_o),
        .wb_valid_i   (wb_valid_i),
        .wb_idx_i     (wb_idx_i),
        .stall_cnt_o  (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int rs1;
        bit r1en;
        int rs2;
        bit r2en;
        int rd;
        bit wen;
        bit mc;
        bit ld;
        bit flush;
        bit done;
        bit wbv;
        int wbidx;
    } stim_t;

    int checks = 0;
    int errors = 0;

    // Reference model: which registers await a write, whether a multi-cycle op
    // is in flight, and whether this is its writeback cycle.
    bit pend[NREG];
    bit m_inflight;
    bit m_wb_now;
    int m_dst;
    bit m_ex_valid;
    int m_ex_idx;
    bit m_start;
    int m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.valid = 0; s.rs1 = 0; s.r1en = 0; s.rs2 = 0; s.r2en = 0;
        s.rd = 0; s.wen = 0; s.mc = 0; s.ld = 0; s.flush = 0;
        s.done = 0; s.wbv = 0; s.wbidx = 0;
        return s;
    endfunction

    function automatic stim_t op(input int rs1, input int rs2, input int rd);
        stim_t s = idle();
        s.valid = 1; s.rs1 = rs1; s.r1en = 1; s.rs2 = rs2; s.r2en = 1;
        s.rd = rd; s.wen = 1;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s = idle();
        s.valid = ($urandom_range(0, 9) < 7);
        s.rs1   = $urandom_range(0, 7);
        s.r1en  = $urandom_range(0, 1);
        s.rs2   = $urandom_range(0, 7);
        s.r2en  = $urandom_range(0, 1);
        s.rd    = $urandom_range(0, 7);
        s.wen   = ($urandom_range(0, 3) != 0);
        s.mc    = ($urandom_range(0, 9) < 2);
        s.ld    = !s.mc && ($urandom_range(0, 9) < 3);
        s.flush = ($urandom_range(0, 9) == 0);
        s.done  = ($urandom_range(0, 4) == 0);
        s.wbv   = ($urandom_range(0, 2) == 0);
        s.wbidx = $urandom_range(0, 7);
        return s;
    endfunction

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 0;
        m_inflight = 0;
        m_wb_now   = 0;
        m_dst      = 0;
        m_ex_valid = 0;
        m_ex_idx   = 0;
        m_start    = 0;
        m_cnt      = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        id_valid_i = 0; rs1_idx_i = '0; rs1_ren_i = 0; rs2_idx_i = '0; rs2_ren_i = 0;
        rsd_idx_i = '0; rsd_wen_i = 0; id_mc_i = 0; id_ld_i = 0; flush_i = 0;
        mc_done_i = 0; wb_valid_i = 0; wb_idx_i = '0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_ex_valid", ex_valid_o, 0);
        check("rst_ex_rsd", ex_rsd_idx_o, 0);
        check("rst_mc_start", mc_start_o, 0);
        check("rst_mc_busy", mc_busy_o, 0);
        check("rst_mc_wb", mc_wb_o, 0);
        check("rst_mc_rsd", mc_rsd_idx_o, 0);
        check("rst_stall_cnt", stall_cnt_o, 0);
    endtask

    // One clock: drive, check readiness before the edge, advance the model,
    // check registered outputs after the edge.
    task automatic step(input stim_t s);
        bit haz, ready, fire;
        @(negedge clk);
        rst        = 1'b0;
        id_valid_i = s.valid;
        rs1_idx_i  = s.rs1[RFIDX_W-1:0];
        rs1_ren_i  = s.r1en;
        rs2_idx_i  = s.rs2[RFIDX_W-1:0];
        rs2_ren_i  = s.r2en;
        rsd_idx_i  = s.rd[RFIDX_W-1:0];
        rsd_wen_i  = s.wen;
        id_mc_i    = s.mc;
        id_ld_i    = s.ld;
        flush_i    = s.flush;
        mc_done_i  = s.done;
        wb_valid_i = s.wbv;
        wb_idx_i   = s.wbidx[RFIDX_W-1:0];
        #1;
        haz = (s.r1en && s.rs1 != 0 && pend[s.rs1]) ||
              (s.r2en && s.rs2 != 0 && pend[s.rs2]) ||
              (s.wen  && s.rd  != 0 && pend[s.rd]);
        ready = !haz && !m_inflight;
        check("id_ready", id_ready_o, ready);
        fire = s.valid && ready && !s.flush;

        if (s.valid && !ready && !s.flush && m_cnt < CNT_MAX) m_cnt++;
        m_ex_valid = fire;
        if (fire) m_ex_idx = s.rd;
        m_start = fire && s.mc;

        if (s.wbv && s.wbidx != 0) pend[s.wbidx] = 0;
        if (m_wb_now) pend[m_dst] = 0;
        if (fire && (s.mc || s.ld) && s.wen && s.rd != 0) pend[s.rd] = 1;

        if (m_wb_now) begin
            m_wb_now   = 0;
            m_inflight = 0;
        end else if (m_inflight) begin
            if (s.done) m_wb_now = 1;
        end else if (fire && s.mc) begin
            m_inflight = 1;
            m_dst      = s.rd;
        end

        @(posedge clk);
        #1;
        check("ex_valid", ex_valid_o, m_ex_valid);
        check("ex_rsd_idx", ex_rsd_idx_o, m_ex_idx);
        check("mc_start", mc_start_o, m_start);
        check("mc_busy", mc_busy_o, m_inflight);
        check("mc_wb", mc_wb_o, m_wb_now);
        check("mc_rsd_idx", mc_rsd_idx_o, m_dst);
        check("stall_cnt", stall_cnt_o, m_cnt);
    endtask

    initial begin
        stim_t s, c;
        int    starts, busy_cnt;
        int    waits;

        rst = 1'b1;
        do_reset();

        // Independent add issues with latency 1.
        step(op(1, 2, 3));
        check("add_valid", ex_valid_o, 1);
        check("add_rd", ex_rsd_idx_o, 3);

        // Load to x5, consumer stalls until the clear, fires the cycle after.
        s = op(0, 0, 5); s.r1en = 0; s.r2en = 0; s.ld = 1;
        step(s);
        c = op(5, 0, 6); c.r2en = 0;
        repeat (3) step(c);
        c.wbv = 1; c.wbidx = 5;
        step(c);
        check("raw_no_bypass", ex_valid_o, 0);
        c.wbv = 0;
        step(c);
        check("raw_fire", ex_valid_o, 1);
        check("raw_stalls", stall_cnt_o, 4);

        // Multi-cycle op to x7 with a delayed done and a flush while busy.
        s = op(1, 2, 7); s.mc = 1;
        step(s);
        starts   = int'(mc_start_o);
        busy_cnt = int'(mc_busy_o);
        waits    = 10;
        for (int i = 0; i < waits; i++) begin
            s = idle();
            if (i == 4) begin
                s = op(1, 2, 9); s.flush = 1;
            end
            step(s);
            starts   += int'(mc_start_o);
            busy_cnt += int'(mc_busy_o);
        end
        s = idle(); s.done = 1;
        step(s);
        busy_cnt += int'(mc_busy_o);
        check("mc_wb_seen", mc_wb_o, 1);
        check("mc_wb_idx", mc_rsd_idx_o, 7);
        c = op(7, 0, 8); c.r2en = 0;
        step(c);
        check("mc_dep_stall_in_wb", ex_valid_o, 0);
        step(c);
        check("mc_dep_fire", ex_valid_o, 1);
        check("mc_start_pulses", starts, 1);
        check("mc_busy_cycles", busy_cnt, waits + 2);

        // x0 is never pending; a writeback to x0 is inert.
        s = op(0, 0, 0); s.r1en = 0; s.r2en = 0; s.ld = 1;
        step(s);
        step(op(0, 0, 4));
        check("x0_no_stall", ex_valid_o, 1);
        s = idle(); s.wbv = 1; s.wbidx = 0;
        step(s);

        // Flushed load issues nothing and sets nothing.
        s = op(0, 0, 9); s.r1en = 0; s.r2en = 0; s.ld = 1; s.flush = 1;
        step(s);
        check("flush_no_issue", ex_valid_o, 0);
        step(op(9, 0, 10));
        check("flush_sb_clean", ex_valid_o, 1);

        // Stall counter saturation.
        do_reset();
        s = op(0, 0, 9); s.r1en = 0; s.r2en = 0; s.ld = 1;
        step(s);
        c = op(9, 0, 11); c.r2en = 0;
        repeat (20) step(c);
        check("stall_saturate", stall_cnt_o, CNT_MAX);

        // Reset while busy drops the op without writeback.
        do_reset();
        s = op(1, 2, 4); s.mc = 1;
        step(s);
        repeat (2) step(idle());
        do_reset();
        repeat (3) step(idle());
        step(op(4, 0, 5));
        check("rst_busy_dep_fire", ex_valid_o, 1);

        // Randomized traffic with periodic resets.
        for (int n = 0; n < 3000; n++) begin
            if ((n % 200) == 199) do_reset();
            else step(rnd());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
